gbuf_responder: RTL and testbench
=================================

GBUF_RESPONDER -- requirements
Module: gbuf_responder

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default `WORD_WIDTH, meaning the word width in bits (160 = 10 lanes x 16 bits).
REQ-002 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH, meaning the word address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have port clk_i  in  1  single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-005 SHALL have port en_i  in  1  accelerator-side access enable.
REQ-006 SHALL have port we_i  in  1  accelerator-side write enable; a write requires en_i=1 and we_i=1.
REQ-007 SHALL have port addr_i  in  ADDR_WIDTH  accelerator-side address.
REQ-008 SHALL have port word_i  in  WORD_WIDTH  accelerator-side write data (P results).
REQ-009 SHALL have port word_o  out  WORD_WIDTH  accelerator-side read data (A/B operands).
REQ-010 SHALL have port rvalid_o  out  1  word_o is valid this cycle.
REQ-011 SHALL have port cmd_valid_i / cmd_ready_o  in/out  1  host command handshake.
REQ-012 SHALL have port cmd_dump_i  in  1  0 = load (host to buffer), 1 = dump (buffer to host).
REQ-013 SHALL have ports cmd_base_i and cmd_len_i  in  ADDR_WIDTH+1 (len), ADDR_WIDTH (base)  burst start address and word count.
REQ-014 SHALL have ports hw_valid_i / hw_ready_o / hw_data_i  in/out/in  1/1/WORD_WIDTH  host write-data stream.
REQ-015 SHALL have ports hr_valid_o / hr_ready_i / hr_data_o  out/in/out  1/1/WORD_WIDTH  host read-data stream.
REQ-016 SHALL have ports busy_o and done_o  out  1  burst in progress; one-cycle pulse at burst end.

Function
REQ-017 SHALL use the FSM states IDLE, LOAD, DUMP and DRAIN; cmd_ready_o=1 only in IDLE.
REQ-018 SHALL latch base, len and direction on a cmd_valid_i & cmd_ready_o transfer, then go to LOAD or DUMP; with len=0 it SHALL go straight to IDLE and pulse done_o one cycle later.
REQ-019 SHALL, when en_i=1 and we_i=0, present mem[addr_i] on word_o with rvalid_o=1 exactly 1 cycle later; otherwise rvalid_o=0 and word_o SHALL hold its last value.
REQ-020 SHALL give the accelerator port absolute priority: in any cycle with en_i=1, hw_ready_o=0 and no dump read is issued.
REQ-021 SHALL, in LOAD, write hw_data_i to base+count on each hw_valid_i & hw_ready_o beat and increment count; after beat len it SHALL go to IDLE and pulse done_o.
REQ-022 SHALL, in DUMP, issue a read of base+count only when the 1-entry output holding register is empty or is being emptied that cycle; read data SHALL reach hr_data_o 1 cycle after issue and stay stable while hr_valid_o=1 and hr_ready_i=0.
REQ-023 SHALL move from DUMP to DRAIN after issuing read len, and from DRAIN to IDLE with done_o pulse once the last beat is accepted.
REQ-024 SHALL wrap burst addresses modulo 2**ADDR_WIDTH.
REQ-025 SHALL perform a read and a write to the same address in the same cycle as read-first (old data returned).
REQ-026 SHALL assert busy_o in every state except IDLE.

Reset
REQ-027 SHALL, on rst_i=1, force the FSM to IDLE, count=0, rvalid_o=0, hr_valid_o=0, done_o=0, word_o=0, hr_data_o=0, hw_ready_o=0 and cmd_ready_o=1 in the following cycle.
REQ-028 SHALL abandon any burst interrupted by reset without a done_o pulse; memory contents SHALL NOT be cleared.

Configuration
REQ-029 SHALL honour GBUF_OUT_REG_EN: when defined, the accelerator-side read data and rvalid_o SHALL pass through one extra register (latency 2); when undefined, latency SHALL be 1. The host-side timing SHALL be identical in both builds.

Verification
REQ-030 SHALL have a test: load len=10 at base 0x000 with word i = i+1 in every lane -> 10 beats, done_o pulse, and accelerator reads of 0x000..0x009 return those words 1 cycle later (2 with GBUF_OUT_REG_EN).
REQ-031 SHALL have a test: accelerator writes 0x200..0x209, then dump len=10 base 0x200 with hr_ready_i toggling 1,0,1,0 -> 10 beats in order, no loss or duplication, done_o after the 10th.
REQ-032 SHALL have a test: en_i held 1 during a load -> hw_ready_o=0 throughout; the burst completes after en_i drops.
REQ-033 SHALL have a test: dump base 0xFFE len=4 -> data from 0xFFE, 0xFFF, 0x000, 0x001.
REQ-034 SHALL have a test: same-cycle accelerator read and host write to 0x005 -> the old value is returned.
REQ-035 SHALL have a test: rst_i asserted mid-dump after 3 beats -> IDLE and cmd_ready_o=1 next cycle, no done_o pulse, and the memory is intact on re-read.

Source files
------------

// File: rtl/gbuf_responder_if.sv
// Host-side command, write-data and read-data streams of gbuf_responder.
// WORD_WIDTH / ADDR_WIDTH macros default to 160 / 12 when not supplied.
`ifndef WORD_WIDTH
`define WORD_WIDTH 160
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

interface gbuf_responder_if #(
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_dump_i;
  logic [ADDR_WIDTH-1:0] cmd_base_i;
  logic [ADDR_WIDTH:0]   cmd_len_i;
  logic                  hw_valid_i;
  logic                  hw_ready_o;
  logic [WORD_WIDTH-1:0] hw_data_i;
  logic                  hr_valid_o;
  logic                  hr_ready_i;
  logic [WORD_WIDTH-1:0] hr_data_o;

  modport slave (
    input  cmd_valid_i, cmd_dump_i, cmd_base_i, cmd_len_i,
    input  hw_valid_i, hw_data_i, hr_ready_i,
    output cmd_ready_o, hw_ready_o, hr_valid_o, hr_data_o
  );

  modport master (
    output cmd_valid_i, cmd_dump_i, cmd_base_i, cmd_len_i,
    output hw_valid_i, hw_data_i, hr_ready_i,
    input  cmd_ready_o, hw_ready_o, hr_valid_o, hr_data_o
  );
endinterface

// File: rtl/gbuf_responder.sv
// Global buffer: accelerator word port plus host load/dump burst engine.
// Define GBUF_OUT_REG_EN to add one output register on the accelerator read path.
`ifndef WORD_WIDTH
`define WORD_WIDTH 160
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

module gbuf_responder #(
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  rvalid_o,
  output logic                  busy_o,
  output logic                  done_o,
  gbuf_responder_if.slave       host
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, DUMP, DRAIN} state_e;

  state_e state_q, state_d;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  done_q, done_d;
  logic                  rvalid_q, rvalid_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic                  hr_valid_q, hr_valid_d;
  logic [WORD_WIDTH-1:0] hr_data_q, hr_data_d;

  logic                  cmd_fire;
  logic                  load_beat;
  logic                  dump_issue;
  logic                  hr_pop;
  logic                  last_count;
  logic [ADDR_WIDTH-1:0] burst_addr;

  assign burst_addr = base_q + count_q[ADDR_WIDTH-1:0];
  assign last_count = (count_q + 1'b1) == len_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a zero-length command never leaves IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (cmd_fire && host.cmd_len_i != '0)
          state_d = host.cmd_dump_i ? DUMP : LOAD;
      LOAD:
        if (load_beat && last_count) state_d = IDLE;
      DUMP:
        if (dump_issue && last_count) state_d = DRAIN;
      DRAIN:
        if (hr_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; the accelerator port always wins the memory.
  always_comb begin
    host.cmd_ready_o = (state_q == IDLE);
    host.hw_ready_o  = (state_q == LOAD) && !en_i;
    busy_o           = (state_q != IDLE);
    cmd_fire         = host.cmd_valid_i && (state_q == IDLE);
    load_beat        = host.hw_valid_i && (state_q == LOAD) && !en_i;
    hr_pop           = hr_valid_q && host.hr_ready_i;
    dump_issue       = (state_q == DUMP) && !en_i
                    && (!hr_valid_q || hr_pop);
  end

  // Burst bookkeeping, host holding register and accelerator read data.
  always_comb begin
    base_d     = base_q;
    len_d      = len_q;
    count_d    = count_q;
    done_d     = 1'b0;
    hr_valid_d = hr_valid_q;
    hr_data_d  = hr_data_q;
    if (cmd_fire) begin
      base_d  = host.cmd_base_i;
      len_d   = host.cmd_len_i;
      count_d = '0;
      done_d  = (host.cmd_len_i == '0);
    end
    if (load_beat || dump_issue) count_d = count_q + 1'b1;
    if (load_beat && last_count) done_d = 1'b1;
    if (state_q == DRAIN && hr_pop) done_d = 1'b1;
    if (hr_pop) hr_valid_d = 1'b0;
    if (dump_issue) begin
      hr_valid_d = 1'b1;
      hr_data_d  = mem[burst_addr];
    end
    rvalid_d = en_i && !we_i;
    rdata_d  = rvalid_d ? mem[addr_i] : rdata_q;
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      hr_valid_q <= 1'b0;
      hr_data_q  <= '0;
    end else begin
      base_q     <= base_d;
      len_q      <= len_d;
      count_q    <= count_d;
      done_q     <= done_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      hr_valid_q <= hr_valid_d;
      hr_data_q  <= hr_data_d;
    end
  end

  // Storage is never cleared; reads above see the pre-write value.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i)   mem[addr_i]     <= word_i;
    else if (load_beat) mem[burst_addr] <= host.hw_data_i;
  end

`ifdef GBUF_OUT_REG_EN
  logic                  rvalid2_q, rvalid2_d;
  logic [WORD_WIDTH-1:0] rdata2_q, rdata2_d;

  // Extra output stage; word holds whenever no new read arrives.
  always_comb begin
    rvalid2_d = rvalid_q;
    rdata2_d  = rvalid_q ? rdata_q : rdata2_q;
  end

  // Output stage registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid2_q <= 1'b0;
      rdata2_q  <= '0;
    end else begin
      rvalid2_q <= rvalid2_d;
      rdata2_q  <= rdata2_d;
    end
  end

  assign rvalid_o = rvalid2_q;
  assign word_o   = rdata2_q;
`else
  assign rvalid_o = rvalid_q;
  assign word_o   = rdata_q;
`endif

  assign done_o          = done_q;
  assign host.hr_valid_o = hr_valid_q;
  assign host.hr_data_o  = hr_data_q;

endmodule

// File: tb/tb_gbuf_responder.sv
// Directed + randomized bench for gbuf_responder.
// Reference memory model and burst rules are tracked with plain arrays/queues.
module tb_gbuf_responder;
  localparam int WW    = 160;
  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;
`ifdef GBUF_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic          en_i;
  logic          we_i;
  logic [AW-1:0] addr_i;
  logic [WW-1:0] word_i;
  logic [WW-1:0] word_o;
  logic          rvalid_o;
  logic          busy_o;
  logic          done_o;

  gbuf_responder_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) hif ();

  gbuf_responder #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .word_i   (word_i),
    .word_o   (word_o),
    .rvalid_o (rvalid_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .host     (hif)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mdl [DEPTH];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [WW-1:0] obs,
                     input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [WW-1:0] lane_word(input int i);
    logic [15:0] v;
    v = 16'(i + 1);
    return {10{v}};
  endfunction

  task automatic send_cmd(input bit dump, input int base, input int len);
    hif.cmd_valid_i = 1'b1;
    hif.cmd_dump_i  = dump;
    hif.cmd_base_i  = AW'(base);
    hif.cmd_len_i   = (AW+1)'(len);
    @(negedge clk);
    chk("cmd_ready", hif.cmd_ready_o, 1'b1);
    tick();
    hif.cmd_valid_i = 1'b0;
    if (len == 0) begin
      chk("len0_done", done_o, 1'b1);
      chk("len0_idle", hif.cmd_ready_o, 1'b1);
      tick();
      chk("len0_pulse", done_o, 1'b0);
    end else begin
      chk("cmd_busy", busy_o, 1'b1);
    end
  endtask

  // vmode: 0 always valid, 1 random; enmode: 0 off, 1 random, 2 high first 12 cycles
  task automatic load(input int base, input int len, input int vmode,
                      input int enmode, input bit lanes);
    int beats = 0;
    int cyc = 0;
    bit acc;
    logic [WW-1:0] d;
    send_cmd(1'b0, base, len);
    if (len == 0) return;
    d = lanes ? lane_word(0) : rnd_word();
    while (beats < len && cyc < 20000) begin
      hif.hw_valid_i = (vmode == 0) || ($urandom_range(0, 2) != 0);
      hif.hw_data_i  = d;
      if (enmode == 2)      en_i = (cyc < 12);
      else if (enmode == 1) en_i = ($urandom_range(0, 3) == 0);
      else                  en_i = 1'b0;
      we_i   = 1'b0;
      addr_i = AW'($urandom);
      @(negedge clk);
      chk("hw_ready", hif.hw_ready_o, !en_i);
      acc = hif.hw_valid_i && !en_i;
      tick();
      cyc++;
      if (acc) begin
        mdl[(base + beats) % DEPTH] = d;
        beats++;
        d = lanes ? lane_word(beats) : rnd_word();
      end
      chk("load_done", done_o, beats == len);
    end
    if (beats != len) chk("load_timeout", beats, len);
    hif.hw_valid_i = 1'b0;
    en_i = 1'b0;
    tick();
    chk("load_end_pulse", done_o, 1'b0);
    chk("load_end_busy", busy_o, 1'b0);
  endtask

  // rmode: 0 ready 1,0,1,0..., 1 always ready, 2 random
  task automatic dump(input int base, input int len, input int rmode,
                      input int enmode, input int abort_at);
    logic [WW-1:0] q[$];
    logic [WW-1:0] held;
    int popped = 0;
    int cyc = 0;
    bit stall = 1'b0;
    for (int i = 0; i < len; i++) q.push_back(mdl[(base + i) % DEPTH]);
    send_cmd(1'b1, base, len);
    if (len == 0) return;
    while (popped < len && cyc < 20000) begin
      if (rmode == 0)      hif.hr_ready_i = (cyc % 2 == 0);
      else if (rmode == 1) hif.hr_ready_i = 1'b1;
      else                 hif.hr_ready_i = 1'($urandom_range(0, 1));
      en_i   = (enmode != 0) && ($urandom_range(0, 3) == 0);
      we_i   = 1'b0;
      addr_i = AW'($urandom);
      @(negedge clk);
      if (stall) begin
        chk("hr_hold_valid", hif.hr_valid_o, 1'b1);
        chk("hr_hold_data", hif.hr_data_o, held);
      end
      stall = hif.hr_valid_o && !hif.hr_ready_i;
      held  = hif.hr_data_o;
      if (hif.hr_valid_o && hif.hr_ready_i) begin
        chk("dump_data", hif.hr_data_o, q.pop_front());
        popped++;
      end
      tick();
      cyc++;
      if (popped == abort_at) begin
        rst_i = 1'b1;
        en_i = 1'b0;
        hif.hr_ready_i = 1'b0;
        tick();
        chk("rst_cmd_ready", hif.cmd_ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_hr_valid", hif.hr_valid_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        rst_i = 1'b0;
        tick();
        chk("rst_no_done", done_o, 1'b0);
        return;
      end
      chk("dump_done", done_o, popped == len);
    end
    if (popped != len) chk("dump_timeout", popped, len);
    hif.hr_ready_i = 1'b0;
    en_i = 1'b0;
    tick();
    chk("dump_end_pulse", done_o, 1'b0);
    chk("dump_end_hr_valid", hif.hr_valid_o, 1'b0);
  endtask

  task automatic acc_read(input int a);
    en_i   = 1'b1;
    we_i   = 1'b0;
    addr_i = AW'(a);
    tick();
    en_i = 1'b0;
    repeat (LAT - 1) tick();
    chk("rd_valid", rvalid_o, 1'b1);
    chk("rd_data", word_o, mdl[a % DEPTH]);
    tick();
    chk("rd_gap", rvalid_o, 1'b0);
    chk("rd_hold", word_o, mdl[a % DEPTH]);
  endtask

  task automatic acc_write(input int a, input logic [WW-1:0] d);
    en_i   = 1'b1;
    we_i   = 1'b1;
    addr_i = AW'(a);
    word_i = d;
    tick();
    en_i = 1'b0;
    we_i = 1'b0;
    mdl[a % DEPTH] = d;
  endtask

  initial begin
    logic [WW-1:0] old_w;
    logic [WW-1:0] new_w;
    int base;
    int len;
    rst_i = 1'b1;
    en_i = 1'b0;
    we_i = 1'b0;
    addr_i = '0;
    word_i = '0;
    hif.cmd_valid_i = 1'b0;
    hif.cmd_dump_i = 1'b0;
    hif.cmd_base_i = '0;
    hif.cmd_len_i = '0;
    hif.hw_valid_i = 1'b0;
    hif.hw_data_i = '0;
    hif.hr_ready_i = 1'b0;
    tick();
    tick();
    chk("reset_cmd_ready", hif.cmd_ready_o, 1'b1);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_done", done_o, 1'b0);
    chk("reset_rvalid", rvalid_o, 1'b0);
    chk("reset_word", word_o, '0);
    chk("reset_hr_valid", hif.hr_valid_o, 1'b0);
    chk("reset_hr_data", hif.hr_data_o, '0);
    chk("reset_hw_ready", hif.hw_ready_o, 1'b0);
    rst_i = 1'b0;
    tick();

    load(0, DEPTH, 0, 0, 1'b0);

    load(0, 10, 0, 0, 1'b1);
    for (int i = 0; i < 10; i++) acc_read(i);

    for (int i = 0; i < 10; i++) acc_write('h200 + i, rnd_word());
    dump('h200, 10, 0, 0, -1);

    load('h100, 6, 0, 2, 1'b0);
    for (int i = 0; i < 6; i++) acc_read('h100 + i);

    acc_write('hFFE, rnd_word());
    acc_write('hFFF, rnd_word());
    acc_write('h000, rnd_word());
    acc_write('h001, rnd_word());
    dump('hFFE, 4, 1, 0, -1);

    old_w = mdl[5];
    new_w = rnd_word();
    send_cmd(1'b0, 5, 1);
    en_i = 1'b1;
    we_i = 1'b0;
    addr_i = AW'(5);
    hif.hw_valid_i = 1'b1;
    hif.hw_data_i = new_w;
    @(negedge clk);
    chk("coll_hw_ready", hif.hw_ready_o, 1'b0);
    tick();
    en_i = 1'b0;
    repeat (LAT - 1) tick();
    chk("coll_rvalid", rvalid_o, 1'b1);
    chk("coll_old", word_o, old_w);
    for (int k = 0; k < 10 && !done_o; k++) tick();
    chk("coll_done", done_o, 1'b1);
    hif.hw_valid_i = 1'b0;
    mdl[5] = new_w;
    tick();
    acc_read(5);

    send_cmd(1'b0, 7, 0);
    send_cmd(1'b1, 9, 0);

    for (int it = 0; it < 12; it++) begin
      base = int'($urandom_range(0, DEPTH - 1));
      len  = int'($urandom_range(0, 20));
      if ($urandom_range(0, 1) == 0) load(base, len, 1, 1, 1'b0);
      else dump(base, len, 2, 1, -1);
    end
    acc_read(int'($urandom_range(0, DEPTH - 1)));

    dump('h200, 10, 1, 0, 3);
    for (int i = 0; i < 10; i++) acc_read('h200 + i);
    dump('h200, 10, 2, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
